// File: rtl/conv1_mem_write_if.sv
// Pixel-in / memory-write bundle for conv1_mem_write.
// master drives start and pixels; slave is the writer block.
interface conv1_mem_write_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, done
    );
endinterface

// File: rtl/conv1_mem_write.sv
// Streams one raster-order conv1 image into memory, one write per pixel.
// Optional macro CONV1_WR_RELU_EN clamps negative pixels to 0 before storage.
module conv1_mem_write #(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input logic              clk,
    input logic              reset_n,
    conv1_mem_write_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] pix;
    logic              wr_en;
    logic              done;
    logic              in_ready;
    logic              accept;
    logic              last;
    logic              arm;

    assign accept = bus.in_valid && (state == WRITE);
    assign last   = (row == ROW_LAST) && (col == COL_LAST);
    assign arm    = bus.start && (state != WRITE);

`ifdef CONV1_WR_RELU_EN
    assign pix = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
    assign pix = bus.in_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next state: arm from IDLE/DONE, finish on the last pixel.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.start) next_state = WRITE;
            WRITE:   if (accept && last) next_state = DONE;
            DONE:    if (bus.start) next_state = WRITE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake output decoded from state.
    always_comb begin
        in_ready = 1'b0;
        if (state == WRITE) in_ready = 1'b1;
    end

    // Raster counters, running address and the registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row     <= '0;
            col     <= '0;
            addr    <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en <= accept;
            done  <= (next_state == DONE);
            if (arm) begin
                row  <= '0;
                col  <= '0;
                addr <= '0;
            end else if (accept) begin
                wr_addr <= addr;
                wr_data <= pix;
                addr    <= addr + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.done     = done;
endmodule

// File: tb/tb_conv1_mem_write.sv
// Directed bench for conv1_mem_write: vector table plus
// full-pass, stall, restart, mid-pass start and reset sequences.
module tb_conv1_mem_write;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    conv1_mem_write_if #(.DATA_W(16), .ADDR_W(10)) bus ();

    conv1_mem_write #(
        .IMG_W(24), .IMG_H(24), .DATA_W(16), .ADDR_W(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

`ifdef CONV1_WR_RELU_EN
    localparam logic [15:0] NEG5_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG5_EXP = 16'hfffb;
`endif

    typedef struct {
        logic        start;
        logic        valid;
        logic [15:0] data;
        logic        ready;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic        done;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [15:0] d);
        bus.start    = s;
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_we"},    32'(bus.wr_en),    32'd0);
        chk({tag, "_addr"},  32'(bus.wr_addr),  32'd0);
        chk({tag, "_data"},  32'(bus.wr_data),  32'd0);
        chk({tag, "_done"},  32'(bus.done),     32'd0);
    endtask

    initial begin
        int n;
        logic v;

        vecs[0] = '{1'b0, 1'b1, 16'd11,  1'b0, 1'b0, 10'd0, 16'd0,   1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'd12,  1'b0, 1'b0, 10'd0, 16'd0,   1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'd13,  1'b1, 1'b0, 10'd0, 16'd0,   1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'd100, 1'b1, 1'b1, 10'd0, 16'd100, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'd200, 1'b1, 1'b0, 10'd0, 16'd100, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'hfffb, 1'b1, 1'b1, 10'd1, NEG5_EXP, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'd7,   1'b1, 1'b1, 10'd2, 16'd7,   1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'd0,   1'b1, 1'b0, 10'd2, 16'd7,   1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'd9,   1'b1, 1'b1, 10'd3, 16'd9,   1'b0};

        drive(1'b0, 1'b1, 16'd55);
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].start, vecs[i].valid, vecs[i].data);
            step();
            chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].ready));
            chk($sformatf("vec%0d_we", i),    32'(bus.wr_en),    32'(vecs[i].we));
            chk($sformatf("vec%0d_addr", i),  32'(bus.wr_addr),  32'(vecs[i].addr));
            chk($sformatf("vec%0d_data", i),  32'(bus.wr_data),  32'(vecs[i].wdata));
            chk($sformatf("vec%0d_done", i),  32'(bus.done),     32'(vecs[i].done));
        end

        // abandon the table pass with a reset
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst1");
        @(negedge clk);
        reset_n = 1'b1;

        // full back-to-back pass
        drive(1'b1, 1'b0, 16'd0);
        step();
        chk("full_arm_ready", 32'(bus.in_ready), 32'd1);
        chk("full_arm_we", 32'(bus.wr_en), 32'd0);
        for (int i = 0; i < 576; i++) begin
            drive(1'b0, 1'b1, 16'(i));
            step();
            chk($sformatf("full_we_%0d", i),   32'(bus.wr_en),   32'd1);
            chk($sformatf("full_addr_%0d", i), 32'(bus.wr_addr), 32'(i));
            chk($sformatf("full_data_%0d", i), 32'(bus.wr_data), 32'(i));
            chk($sformatf("full_done_%0d", i), 32'(bus.done),    32'(i == 575));
        end
        drive(1'b0, 1'b1, 16'd77);
        step();
        chk("after_done_ready", 32'(bus.in_ready), 32'd0);
        chk("after_done_we", 32'(bus.wr_en), 32'd0);
        chk("after_done_done", 32'(bus.done), 32'd1);
        chk("after_done_addr", 32'(bus.wr_addr), 32'd575);

        // restart from DONE with valid toggling
        drive(1'b1, 1'b0, 16'd0);
        step();
        chk("restart_done", 32'(bus.done), 32'd0);
        chk("restart_ready", 32'(bus.in_ready), 32'd1);
        n = 0;
        for (int c = 0; c < 1152; c++) begin
            v = (c % 2 == 0);
            drive(1'b0, v, 16'(n + 1000));
            step();
            if (v) begin
                chk($sformatf("tog_we_%0d", c),   32'(bus.wr_en),   32'd1);
                chk($sformatf("tog_addr_%0d", c), 32'(bus.wr_addr), 32'(n));
                chk($sformatf("tog_data_%0d", c), 32'(bus.wr_data), 32'(n + 1000));
                n++;
            end else begin
                chk($sformatf("tog_we_%0d", c),   32'(bus.wr_en),   32'd0);
                chk($sformatf("tog_addr_%0d", c), 32'(bus.wr_addr), 32'(n - 1));
            end
            chk($sformatf("tog_done_%0d", c), 32'(bus.done), 32'(n == 576));
        end

        // mid-pass start ignored, then reset at pixel 300
        drive(1'b1, 1'b0, 16'd0);
        step();
        for (int i = 0; i < 300; i++) begin
            drive(i == 100, 1'b1, 16'(i));
            step();
            chk($sformatf("mid_addr_%0d", i), 32'(bus.wr_addr), 32'(i));
            chk($sformatf("mid_we_%0d", i), 32'(bus.wr_en), 32'd1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst2");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 16'd77);
            step();
            chk($sformatf("idle_ready_%0d", i), 32'(bus.in_ready), 32'd0);
            chk($sformatf("idle_we_%0d", i), 32'(bus.wr_en), 32'd0);
        end
        drive(1'b1, 1'b1, 16'd5);
        step();
        chk("post_arm_ready", 32'(bus.in_ready), 32'd1);
        chk("post_arm_we", 32'(bus.wr_en), 32'd0);
        drive(1'b0, 1'b1, 16'd42);
        step();
        chk("post_first_we", 32'(bus.wr_en), 32'd1);
        chk("post_first_addr", 32'(bus.wr_addr), 32'd0);
        chk("post_first_data", 32'(bus.wr_data), 32'd42);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
